// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch/decode definitions: FSM encoding, widths, and the
// instruction field boundaries used by the decoder.
package instruction_fetch_unit_pkg;

    localparam int IFU_ADDR_W = 8;
    localparam int INSTR_W    = 16;

    localparam int OPCODE_MSB  = 15;
    localparam int OPCODE_LSB  = 8;
    localparam int OPERAND_MSB = 7;
    localparam int OPERAND_LSB = 0;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, fetches over a req/ack handshake and
// holds the latched instruction until execute reports completion.
import instruction_fetch_unit_pkg::*;

module instruction_fetch_unit #(
    parameter int                ADDR_W   = IFU_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instruction_register,
    output logic               ir_valid,
    output logic [ADDR_W-1:0]  program_counter,
    input  logic               exec_done,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target
);

    ifu_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               valid_q, valid_d;
    logic               req_q, req_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        valid_d = valid_q;
        req_d   = req_q;
        unique case (state_q)
            ST_RST: begin
                state_d = ST_REQ;
                req_d   = 1'b1;
            end
            ST_REQ, ST_WAIT: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                // PC was already advanced at fetch; only a branch overrides it
                if (exec_done) begin
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                    if (branch_taken) begin
                        pc_d = branch_target;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_RST;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

    assign mem_req              = req_q;
    assign mem_addr             = pc_q;
    assign instruction_register = ir_q;
    assign ir_valid             = valid_q;
    assign program_counter      = pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed steps plus
// randomized traffic against a rule-level reference model.
module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] instruction_register;
    logic        ir_valid;
    logic [7:0]  program_counter;
    logic        exec_done = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = '0;

    logic        w_reset_n = 1'b0;
    logic        w_req;
    logic [7:0]  w_addr;
    logic        w_ack = 1'b1;
    logic [15:0] w_rdata = 16'h1357;
    logic [15:0] w_ir;
    logic        w_valid;
    logic [7:0]  w_pc;
    logic        w_exec_done = 1'b0;
    logic        w_branch_taken = 1'b0;
    logic [7:0]  w_branch_target = '0;

    int tests = 0;
    int fails = 0;

    // reference model state
    bit          m_in_reset = 1'b1;
    bit          m_req = 1'b0;
    bit          m_valid = 1'b0;
    logic [7:0]  m_pc = 8'h00;
    logic [15:0] m_ir = 16'h0000;

    always #5 clock = ~clock;

    instruction_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .instruction_register(instruction_register),
        .ir_valid(ir_valid),
        .program_counter(program_counter),
        .exec_done(exec_done),
        .branch_taken(branch_taken),
        .branch_target(branch_target)
    );

    instruction_fetch_unit #(.ADDR_W(8), .RESET_PC(8'hFF)) dut_wrap (
        .clock(clock),
        .reset_n(w_reset_n),
        .mem_req(w_req),
        .mem_addr(w_addr),
        .mem_ack(w_ack),
        .mem_rdata(w_rdata),
        .instruction_register(w_ir),
        .ir_valid(w_valid),
        .program_counter(w_pc),
        .exec_done(w_exec_done),
        .branch_taken(w_branch_taken),
        .branch_target(w_branch_target)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic cyc(input logic rn, input logic ack,
                       input logic [15:0] rd, input logic ed,
                       input logic bt, input logic [7:0] tg);
        @(negedge clock);
        reset_n       = rn;
        mem_ack       = ack;
        mem_rdata     = rd;
        exec_done     = ed;
        branch_taken  = bt;
        branch_target = tg;
        if (!rn) begin
            m_in_reset = 1'b1;
            m_req      = 1'b0;
            m_valid    = 1'b0;
            m_pc       = 8'h00;
            m_ir       = 16'h0000;
        end else if (m_in_reset) begin
            m_in_reset = 1'b0;
            m_req      = 1'b1;
        end else if (m_req) begin
            if (ack) begin
                m_ir    = rd;
                m_pc    = m_pc + 8'd1;
                m_valid = 1'b1;
                m_req   = 1'b0;
            end
        end else if (m_valid && ed) begin
            m_valid = 1'b0;
            m_req   = 1'b1;
            if (bt) m_pc = tg;
        end
        @(posedge clock);
        #1;
        chk("mem_req", {15'd0, mem_req}, {15'd0, m_req});
        chk("mem_addr", {8'd0, mem_addr}, {8'd0, m_pc});
        chk("ir", instruction_register, m_ir);
        chk("ir_valid", {15'd0, ir_valid}, {15'd0, m_valid});
        chk("pc", {8'd0, program_counter}, {8'd0, m_pc});
        chk("valid_and_req", {15'd0, ir_valid & mem_req}, 16'd0);
    endtask

    initial begin
        // reset
        cyc(0, 0, 16'h0, 0, 0, 8'h0);
        cyc(0, 1, 16'hDEAD, 1, 1, 8'h77);
        chk("rst_req", {15'd0, mem_req}, 16'd0);
        chk("rst_addr", {8'd0, mem_addr}, 16'h0000);
        chk("rst_ir", instruction_register, 16'h0000);
        chk("rst_valid", {15'd0, ir_valid}, 16'd0);

        // zero-wait fetch
        cyc(1, 1, 16'h0205, 0, 0, 8'h0);
        chk("zw_req", {15'd0, mem_req}, 16'd1);
        chk("zw_addr", {8'd0, mem_addr}, 16'h0000);
        cyc(1, 1, 16'h0205, 0, 0, 8'h0);
        chk("zw_ir", instruction_register, 16'h0205);
        chk("zw_valid", {15'd0, ir_valid}, 16'd1);
        chk("zw_pc", {8'd0, program_counter}, 16'h0001);

        // branch on completion
        cyc(1, 0, 16'h0, 1, 1, 8'h40);
        chk("br_req", {15'd0, mem_req}, 16'd1);
        chk("br_addr", {8'd0, mem_addr}, 16'h0040);

        // three-cycle latency, spurious exec_done while waiting
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 16'h1111, 1, 1, 8'h99);
            chk("wait_req", {15'd0, mem_req}, 16'd1);
            chk("wait_addr", {8'd0, mem_addr}, 16'h0040);
            chk("wait_ir", instruction_register, 16'h0205);
        end
        cyc(1, 1, 16'hABCD, 0, 0, 8'h0);
        chk("lat_ir", instruction_register, 16'hABCD);
        chk("lat_pc", {8'd0, program_counter}, 16'h0041);

        // ack and branch without exec_done in HOLD are ignored
        cyc(1, 1, 16'hFFFF, 0, 1, 8'h10);
        chk("hold_ir", instruction_register, 16'hABCD);
        chk("hold_pc", {8'd0, program_counter}, 16'h0041);
        chk("hold_valid", {15'd0, ir_valid}, 16'd1);

        // sequential advance
        cyc(1, 0, 16'h0, 1, 0, 8'h22);
        chk("seq_addr", {8'd0, mem_addr}, 16'h0041);

        // reset during WAIT with ack on the same edge
        cyc(1, 0, 16'h0, 0, 0, 8'h0);
        cyc(0, 1, 16'h1234, 0, 0, 8'h0);
        chk("rw_ir", instruction_register, 16'h0000);
        chk("rw_valid", {15'd0, ir_valid}, 16'd0);
        chk("rw_pc", {8'd0, program_counter}, 16'h0000);
        chk("rw_req", {15'd0, mem_req}, 16'd0);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            cyc(($urandom_range(0, 49) != 0),
                ($urandom_range(0, 1) == 1),
                16'($urandom),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 1) == 1),
                8'($urandom));
        end

        // PC wrap from RESET_PC = 8'hFF
        @(negedge clock);
        w_reset_n = 1'b0;
        @(negedge clock);
        w_reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("wrap_req1", {15'd0, w_req}, 16'd1);
        chk("wrap_addr1", {8'd0, w_addr}, 16'h00FF);
        @(posedge clock);
        #1;
        chk("wrap_ir", w_ir, 16'h1357);
        chk("wrap_pc", {8'd0, w_pc}, 16'h0000);
        @(negedge clock);
        w_exec_done = 1'b1;
        @(posedge clock);
        #1;
        w_exec_done = 1'b0;
        chk("wrap_req2", {15'd0, w_req}, 16'd1);
        chk("wrap_addr2", {8'd0, w_addr}, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
